// File: rtl/rs_msg_framer.sv
// Byte FIFO plus frame sequencer: slices captured UART bytes into fixed MSG_LEN-symbol
// frames for the RS encoder, zero-padding a partial frame after TIMEOUT idle cycles.
module rs_msg_framer #(
  parameter int MSG_LEN    = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int TIMEOUT    = 1000
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_byte,
  input  logic                          in_ce,
  output logic [7:0]                    enc_data,
  output logic                          enc_valid,
  output logic                          enc_sop,
  output logic                          enc_eop,
  input  logic                          enc_ready,
  output logic                          padded,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(MSG_LEN + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, SEND} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] sym_q, sym_d, n_real_q, n_real_d;
  logic [7:0]    enc_data_q, enc_data_d;
  logic          enc_valid_q, enc_valid_d;
  logic          enc_sop_q, enc_sop_d, enc_eop_q, enc_eop_d;
  logic          padded_q, padded_d;

  logic full, push, load, pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot for the push.
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign push = in_ce & ~full;
  assign load = (state_q == SEND) && (sym_q != SW'(MSG_LEN)) && (!enc_valid_q || enc_ready);
  assign pop  = load && (sym_q < n_real_q);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_byte;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (in_ce & full);
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    sym_d       = sym_q;
    n_real_d    = n_real_q;
    enc_data_d  = enc_data_q;
    enc_valid_d = enc_valid_q;
    enc_sop_d   = enc_sop_q;
    enc_eop_d   = enc_eop_q;
    padded_d    = padded_q;
    case (state_q)
      IDLE: begin
        if (count_q >= CW'(MSG_LEN)) begin
          state_d  = SEND;
          n_real_d = SW'(MSG_LEN);
          padded_d = 1'b0;
          sym_d    = '0;
          timer_d  = '0;
        end else if (count_q != '0 && timer_q == TW'(TIMEOUT - 1)) begin
          state_d  = SEND;
          n_real_d = SW'(count_q);
          padded_d = 1'b1;
          sym_d    = '0;
          timer_d  = '0;
        end else if (in_ce || count_q == '0) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SEND: begin
        timer_d = '0;
        if (load) begin
          // Symbols past n_real are pad zeros and do not touch the FIFO.
          enc_valid_d = 1'b1;
          enc_data_d  = (sym_q < n_real_q) ? mem_q[rd_ptr_q] : 8'h00;
          enc_sop_d   = (sym_q == '0);
          enc_eop_d   = (sym_q == SW'(MSG_LEN - 1));
          sym_d       = sym_q + SW'(1);
        end else if (enc_valid_q && enc_ready) begin
          enc_valid_d = 1'b0;
          enc_sop_d   = 1'b0;
          enc_eop_d   = 1'b0;
          if (enc_eop_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= IDLE;
      timer_q     <= '0;
      sym_q       <= '0;
      n_real_q    <= '0;
      enc_data_q  <= 8'h00;
      enc_valid_q <= 1'b0;
      enc_sop_q   <= 1'b0;
      enc_eop_q   <= 1'b0;
      padded_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      sym_q       <= sym_d;
      n_real_q    <= n_real_d;
      enc_data_q  <= enc_data_d;
      enc_valid_q <= enc_valid_d;
      enc_sop_q   <= enc_sop_d;
      enc_eop_q   <= enc_eop_d;
      padded_q    <= padded_d;
    end
  end

  assign enc_data   = enc_data_q;
  assign enc_valid  = enc_valid_q;
  assign enc_sop    = enc_sop_q;
  assign enc_eop    = enc_eop_q;
  assign padded     = padded_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_rs_msg_framer.sv
// Directed bench for rs_msg_framer: table of frame scenarios plus hand sequences for
// overflow and mid-frame reset.
module tb_rs_msg_framer;

  localparam int MSG_LEN = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_byte = 8'h00;
  logic       in_ce = 1'b0;
  logic [7:0] enc_data;
  logic       enc_valid, enc_sop, enc_eop;
  logic       enc_ready = 1'b0;
  logic       padded, overflow;
  logic [5:0] fifo_count;

  rs_msg_framer #(.MSG_LEN(16), .FIFO_DEPTH(32), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_ce(in_ce),
    .enc_data(enc_data), .enc_valid(enc_valid), .enc_sop(enc_sop), .enc_eop(enc_eop),
    .enc_ready(enc_ready), .padded(padded), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc_n = 0;
  int first_valid = -1;
  logic [7:0] q_data[$];
  logic       q_sop[$], q_eop[$];
  int         q_cyc[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_sop, prev_eop;

  typedef struct {
    int         nbytes;
    logic [7:0] first;
    bit         toggle;
    int         budget;
    int         exp_lat;   // first enc_valid sample, counted from the first strobe cycle
    bit         exp_pad;
  } scen_t;
  scen_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Called at a negedge: drive inputs for the next posedge, record the handshake, advance.
  task automatic cyc(input logic ce, input logic [7:0] b, input logic rdy);
    in_ce = ce; in_byte = b; enc_ready = rdy;
    if (prev_stall) begin
      chk("hold_valid", enc_valid, 1);
      chk("hold_data", enc_data, prev_data);
      chk("hold_sop", enc_sop, prev_sop);
      chk("hold_eop", enc_eop, prev_eop);
    end
    if (enc_valid && first_valid < 0) first_valid = cyc_n;
    if (enc_valid && rdy) begin
      q_data.push_back(enc_data); q_sop.push_back(enc_sop);
      q_eop.push_back(enc_eop);   q_cyc.push_back(cyc_n);
    end
    prev_stall = enc_valid && !rdy;
    prev_data = enc_data; prev_sop = enc_sop; prev_eop = enc_eop;
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic clear_rx();
    q_data.delete(); q_sop.delete(); q_eop.delete(); q_cyc.delete();
    prev_stall = 1'b0;
    first_valid = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_ce = 1'b0; enc_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_rx();
    chk("rst_valid", enc_valid, 0);
    chk("rst_sop", enc_sop, 0);
    chk("rst_eop", enc_eop, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_padded", padded, 0);
  endtask

  task automatic collect(input int nsym, input int budget, input bit toggle);
    int n;
    n = 0;
    while (q_data.size() < nsym && n < budget) begin
      cyc(1'b0, 8'h00, toggle ? (cyc_n % 2 == 1) : 1'b1);
      n++;
    end
  endtask

  task automatic check_frame(input logic [7:0] first, input int nreal, input int nsym, input logic exp_pad);
    logic [7:0] e;
    chk("sym_count", q_data.size(), nsym);
    for (int j = 0; j < q_data.size() && j < nsym; j++) begin
      e = (j < nreal) ? 8'(int'(first) + j) : 8'h00;
      chk("sym_data", q_data[j], e);
      chk("sym_sop", q_sop[j], ((j % MSG_LEN) == 0) ? 1 : 0);
      chk("sym_eop", q_eop[j], ((j % MSG_LEN) == MSG_LEN - 1) ? 1 : 0);
    end
    chk("padded", padded, exp_pad);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs, nsym;
    // full frame; 5-byte timeout flush; toggled ready; two frames back to back
    tbl[0] = '{nbytes: 16, first: 8'h01, toggle: 1'b0, budget: 100,  exp_lat: 18,   exp_pad: 1'b0};
    tbl[1] = '{nbytes: 5,  first: 8'hAA, toggle: 1'b0, budget: 1200, exp_lat: 1006, exp_pad: 1'b1};
    tbl[2] = '{nbytes: 16, first: 8'h01, toggle: 1'b1, budget: 100,  exp_lat: 18,   exp_pad: 1'b0};
    tbl[3] = '{nbytes: 32, first: 8'h40, toggle: 1'b0, budget: 100,  exp_lat: 18,   exp_pad: 1'b0};

    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      do_reset();
      fs = cyc_n;
      for (int i = 0; i < tbl[s].nbytes; i++)
        cyc(1'b1, 8'(int'(tbl[s].first) + i), tbl[s].toggle ? (cyc_n % 2 == 1) : 1'b1);
      nsym = ((tbl[s].nbytes + MSG_LEN - 1) / MSG_LEN) * MSG_LEN;
      collect(nsym, tbl[s].budget, tbl[s].toggle);
      check_frame(tbl[s].first, tbl[s].nbytes, nsym, tbl[s].exp_pad);
      chk("latency", first_valid - fs, tbl[s].exp_lat);
      // eop accepted -> IDLE -> SEND -> sop visible: three samples apart
      if (tbl[s].nbytes > MSG_LEN)
        chk("b2b_gap", (q_cyc.size() > MSG_LEN) ? q_cyc[MSG_LEN] - q_cyc[MSG_LEN-1] : -1, 3);
      repeat (10) cyc(1'b0, 8'h00, 1'b1);
      chk("no_extra", q_data.size(), nsym);
    end

    // Overflow: 40 strobes while the encoder stalls.
    do_reset();
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'(i + 1), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_count", fifo_count, 32);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", enc_data, 8'h01);
    collect(32, 100, 1'b0);
    check_frame(8'h01, 32, 32, 1'b0);
    chk("ovf_sticky", overflow, 1);
    do_reset();

    // Reset asserted while symbol 7 is on the output.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i + 1), 1'b1);
    collect(7, 50, 1'b0);
    chk("mid_sym7", enc_data, 8'h08);
    chk("mid_valid_pre", enc_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_valid", enc_valid, 0);
    chk("mid_count", fifo_count, 0);
    chk("mid_eop", enc_eop, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_rx();
    repeat (5) cyc(1'b0, 8'h00, 1'b1);
    chk("mid_quiet", q_data.size(), 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h90 + i), 1'b1);
    collect(16, 100, 1'b0);
    check_frame(8'h90, 16, 16, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
